// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive arbitration blocks.
// State encodings, default timeout, and a width helper.
package uart_pkg;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_SEND      = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_IDLE = 2'd3;

   localparam int unsigned TMO_DEFAULT = 1024;

   // Ceiling log2 with a floor of 1 so single-value ranges still get a bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// last_grant+1, wrapping modulo N.
module rr_pick
   import uart_pkg::*;
#(
   parameter  int unsigned N = 4,
   localparam int unsigned W = clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_grant,
   output logic [W-1:0] idx,
   output logic         found
);

   // Walk distances from far to near so the nearest requester is assigned last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = int'(N); k >= 1; k--) begin
         for (int i = 0; i < int'(N); i++) begin
            if (req[i] && (i == ((int'(last_grant) + k) % int'(N)))) begin
               idx   = W'(i);
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter feeding one UART transmit controller,
// pacing bytes on tx_rdy with a timeout against a transmitter that never starts.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   parameter  int unsigned TMO   = TMO_DEFAULT,
   localparam int unsigned GW    = clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           tx_din,
   output logic                 tx_din_rdy,
   input  logic                 tx_rdy,
   output logic [GW-1:0]        grant_id,
   output logic                 busy,
   output logic                 tmo_err
);

   localparam int unsigned CW = clog2(TMO);

   logic [1:0]    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic [7:0]    tx_din_q, tx_din_d;
   logic          tx_din_rdy_q, tx_din_rdy_d;
   logic          lastf_q, lastf_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_err_q, tmo_err_d;

   logic [GW-1:0] pick_idx;
   logic          pick_found;
   logic          sel_valid;
   logic          sel_last;
   logic [7:0]    sel_data;

   rr_pick #(.N(N_REQ)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .idx        (pick_idx),
      .found      (pick_found)
   );

   // Mux out the granted requester's lane.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant_q == GW'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      tx_din_d     = tx_din_q;
      tx_din_rdy_d = 1'b0;
      lastf_d      = lastf_q;
      cnt_d        = cnt_q;
      tmo_err_d    = 1'b0;
      req_ready    = '0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (sel_valid && tx_rdy) begin
               req_ready    = N_REQ'(1) << grant_q;
               tx_din_d     = sel_data;
               tx_din_rdy_d = 1'b1;
               lastf_d      = sel_last;
               cnt_d        = '0;
               state_d      = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            // A real busy indication wins over an expiring timeout.
            cnt_d = cnt_q + CW'(1);
            if (!tx_rdy) begin
               state_d = S_WAIT_IDLE;
            end else if (cnt_q == CW'(TMO - 1)) begin
               tmo_err_d = 1'b1;
               state_d   = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (tx_rdy) begin
               if (lastf_q) begin
                  last_grant_d = grant_q;
                  state_d      = S_IDLE;
               end else begin
                  state_d = S_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(N_REQ - 1);
         tx_din_q     <= '0;
         tx_din_rdy_q <= 1'b0;
         lastf_q      <= 1'b0;
         cnt_q        <= '0;
         tmo_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tx_din_q     <= tx_din_d;
         tx_din_rdy_q <= tx_din_rdy_d;
         lastf_q      <= lastf_d;
         cnt_q        <= cnt_d;
         tmo_err_q    <= tmo_err_d;
      end
   end

   assign tx_din     = tx_din_q;
   assign tx_din_rdy = tx_din_rdy_q;
   assign grant_id   = grant_q;
   assign busy       = (state_q != S_IDLE);
   assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-requester byte queues, a simple
// transmitter model on tx_rdy, and per-scenario inline checks.
module tb_uart_tx_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic [7:0]  tx_din;
   logic        tx_din_rdy;
   logic        tx_rdy;
   logic [1:0]  grant_id;
   logic        busy;
   logic        tmo_err;

   uart_tx_arb #(.N_REQ(4), .TMO(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .tx_din     (tx_din),
      .tx_din_rdy (tx_din_rdy),
      .tx_rdy     (tx_rdy),
      .grant_id   (grant_id),
      .busy       (busy),
      .tmo_err    (tmo_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester byte queues: {last, data}
   logic [8:0] src_q [4][$];
   logic [3:0] en;
   logic [3:0] pend;
   logic [9:0] log_q [$];
   int         stb_cyc [$];
   int         tmo_cyc [$];
   int         acc_q [$];
   int         cyc;
   int         dly;
   int         bcnt;
   bit         stuck;
   int         n_chk;
   int         n_fail;

   function automatic logic [9:0] log_at(input int k);
      return (k < log_q.size()) ? log_q[k] : 10'h3ff;
   endfunction

   function automatic int pending_bytes();
      return src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size();
   endfunction

   task automatic clear_logs();
      log_q.delete();
      stb_cyc.delete();
      tmo_cyc.delete();
      acc_q.delete();
   endtask

   // One clock: retire accepted bytes, advance the transmitter model, drive, sample.
   task automatic step();
      logic [8:0] h;
      logic [8:0] tmp;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (pend[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
      end
      pend = '0;
      if (rst) begin
         tx_rdy = 1'b1;
         dly    = 0;
         bcnt   = 0;
      end else if (dly > 0) begin
         dly--;
         if (dly == 0) begin
            tx_rdy = 1'b0;
            bcnt   = 10;
         end
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) tx_rdy = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         if (src_q[i].size() > 0 && en[i]) begin
            h = src_q[i][0];
            req_valid[i]        = 1'b1;
            req_data[8*i +: 8]  = h[7:0];
            req_last[i]         = h[8];
         end else begin
            req_valid[i]        = 1'b0;
            req_data[8*i +: 8]  = 8'h00;
            req_last[i]         = 1'b0;
         end
      end
      #1;
      if (!rst) begin
         pend = req_valid & req_ready;
         for (int i = 0; i < 4; i++) if (pend[i]) acc_q.push_back(i);
         if (tx_din_rdy === 1'b1) begin
            log_q.push_back({grant_id, tx_din});
            stb_cyc.push_back(cyc);
            if (!stuck) dly = 2;
         end
         if (tmo_err === 1'b1) tmo_cyc.push_back(cyc);
      end
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         step();
         if (busy === 1'b0 && pend == 4'b0 && pending_bytes() == 0) done = 1'b1;
      end
      n_chk++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_idle: arbiter not idle after 400 cycles, busy=%b bytes_left=%0d", nm, busy, pending_bytes());
      end
   endtask

   task automatic wait_strobes(input string nm, input int n);
      int t;
      t = 0;
      while (log_q.size() < n && t < 200) begin
         step();
         t++;
      end
      n_chk++;
      if (log_q.size() < n) begin
         n_fail++;
         $display("FAIL %s_strobe: got %0d strobes, required %0d", nm, log_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_chk++; if (tx_din !== 8'h00)   begin n_fail++; $display("FAIL reset_tx_din: got %h expected 00", tx_din); end
      n_chk++; if (tx_din_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_din_rdy: got %b expected 0", tx_din_rdy); end
      n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      n_chk++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_chk++; if (tmo_err !== 1'b0)   begin n_fail++; $display("FAIL reset_tmo_err: got %b expected 0", tmo_err); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      logic [9:0] exp_l [3];
      exp_l[0] = 10'h041; exp_l[1] = 10'h042; exp_l[2] = 10'h043;
      clear_logs();
      src_q[0].push_back({1'b0, 8'h41});
      src_q[0].push_back({1'b0, 8'h42});
      src_q[0].push_back({1'b1, 8'h43});
      wait_idle("single");
      n_chk++; if (log_q.size() != 3) begin n_fail++; $display("FAIL single_count: got %0d strobes expected 3", log_q.size()); end
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (log_at(k) !== exp_l[k]) begin n_fail++; $display("FAIL single_byte%0d: got %h expected %h", k, log_at(k), exp_l[k]); end
      end
      n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
      n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
   endtask

   task automatic test_round_robin();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_logs();
      src_q[1].push_back({1'b1, 8'h11});
      src_q[2].push_back({1'b1, 8'h22});
      wait_idle("rr_a");
      n_chk++; if (log_q.size() != 2) begin n_fail++; $display("FAIL rr_a_count: got %0d expected 2", log_q.size()); end
      n_chk++; if (log_at(0) !== 10'h111) begin n_fail++; $display("FAIL rr_a_first: got %h expected 111", log_at(0)); end
      n_chk++; if (log_at(1) !== 10'h222) begin n_fail++; $display("FAIL rr_a_second: got %h expected 222", log_at(1)); end
      clear_logs();
      src_q[1].push_back({1'b1, 8'h12});
      src_q[0].push_back({1'b1, 8'h01});
      wait_idle("rr_b");
      n_chk++; if (log_q.size() != 2) begin n_fail++; $display("FAIL rr_b_count: got %0d expected 2", log_q.size()); end
      n_chk++; if (log_at(0) !== 10'h001) begin n_fail++; $display("FAIL rr_b_first: got %h expected 001", log_at(0)); end
      n_chk++; if (log_at(1) !== 10'h112) begin n_fail++; $display("FAIL rr_b_second: got %h expected 112", log_at(1)); end
   endtask

   task automatic test_packet_lock();
      logic [9:0] exp_l [5];
      exp_l[0] = 10'h220; exp_l[1] = 10'h221; exp_l[2] = 10'h222;
      exp_l[3] = 10'h223; exp_l[4] = 10'h00a;
      clear_logs();
      for (int k = 0; k < 4; k++) src_q[2].push_back({(k == 3), 8'h20 + 8'(k)});
      wait_strobes("lock", 2);
      src_q[0].push_back({1'b1, 8'h0a});
      wait_idle("lock");
      n_chk++; if (log_q.size() != 5) begin n_fail++; $display("FAIL lock_count: got %0d expected 5", log_q.size()); end
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if (log_at(k) !== exp_l[k]) begin n_fail++; $display("FAIL lock_byte%0d: got %h expected %h", k, log_at(k), exp_l[k]); end
      end
   endtask

   task automatic test_timeout();
      int d0, d1, d2;
      clear_logs();
      stuck = 1'b1;
      src_q[1].push_back({1'b0, 8'h55});
      src_q[1].push_back({1'b1, 8'haa});
      wait_idle("tmo");
      stuck = 1'b0;
      d0 = (stb_cyc.size() > 0 && tmo_cyc.size() > 0) ? tmo_cyc[0] - stb_cyc[0] : -1;
      d1 = (stb_cyc.size() > 1 && tmo_cyc.size() > 0) ? stb_cyc[1] - tmo_cyc[0] : -1;
      d2 = (stb_cyc.size() > 1 && tmo_cyc.size() > 1) ? tmo_cyc[1] - stb_cyc[1] : -1;
      n_chk++; if (stb_cyc.size() != 2) begin n_fail++; $display("FAIL tmo_strobes: got %0d expected 2", stb_cyc.size()); end
      n_chk++; if (tmo_cyc.size() != 2) begin n_fail++; $display("FAIL tmo_pulses: got %0d cycles of tmo_err expected 2", tmo_cyc.size()); end
      n_chk++; if (d0 != 16) begin n_fail++; $display("FAIL tmo_delay0: got %0d cycles expected 16", d0); end
      n_chk++; if (d1 != 2)  begin n_fail++; $display("FAIL tmo_next_byte: got %0d cycles expected 2", d1); end
      n_chk++; if (d2 != 16) begin n_fail++; $display("FAIL tmo_delay1: got %0d cycles expected 16", d2); end
      n_chk++; if (log_at(0) !== 10'h155) begin n_fail++; $display("FAIL tmo_byte0: got %h expected 155", log_at(0)); end
      n_chk++; if (log_at(1) !== 10'h1aa) begin n_fail++; $display("FAIL tmo_byte1: got %h expected 1aa", log_at(1)); end
   endtask

   task automatic test_valid_drop();
      int acc0;
      logic [9:0] exp_l [4];
      exp_l[0] = 10'h330; exp_l[1] = 10'h331; exp_l[2] = 10'h332; exp_l[3] = 10'h111;
      clear_logs();
      src_q[3].push_back({1'b0, 8'h30});
      src_q[3].push_back({1'b0, 8'h31});
      src_q[3].push_back({1'b1, 8'h32});
      wait_strobes("drop", 1);
      en[3] = 1'b0;
      src_q[1].push_back({1'b1, 8'h11});
      acc0 = acc_q.size();
      for (int t = 0; t < 18; t++) step();
      n_chk++; if (acc_q.size() != acc0) begin n_fail++; $display("FAIL drop_accepts: got %0d accepts in window expected 0", acc_q.size() - acc0); end
      n_chk++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL drop_grant: got %0d expected 3", grant_id); end
      n_chk++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL drop_busy: got %b expected 1", busy); end
      en[3] = 1'b1;
      wait_idle("drop");
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (log_at(k) !== exp_l[k]) begin n_fail++; $display("FAIL drop_byte%0d: got %h expected %h", k, log_at(k), exp_l[k]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      src_q[2].push_back({1'b0, 8'h20});
      src_q[2].push_back({1'b0, 8'h21});
      src_q[2].push_back({1'b1, 8'h22});
      src_q[0].push_back({1'b1, 8'h0a});
      wait_strobes("rstmid", 1);
      for (int t = 0; t < 5; t++) step();
      rst = 1'b1;
      src_q[2].delete();
      src_q[2].push_back({1'b1, 8'h2f});
      clear_logs();
      step();
      n_chk++; if (tx_din !== 8'h00)    begin n_fail++; $display("FAIL rstmid_tx_din: got %h expected 00", tx_din); end
      n_chk++; if (tx_din_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_din_rdy: got %b expected 0", tx_din_rdy); end
      n_chk++; if (req_ready !== 4'h0)  begin n_fail++; $display("FAIL rstmid_req_ready: got %b expected 0000", req_ready); end
      n_chk++; if (grant_id !== 2'd0)   begin n_fail++; $display("FAIL rstmid_grant: got %0d expected 0", grant_id); end
      n_chk++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      rst = 1'b0;
      wait_idle("rstmid");
      n_chk++; if (log_q.size() != 2)    begin n_fail++; $display("FAIL rstmid_count: got %0d expected 2", log_q.size()); end
      n_chk++; if (log_at(0) !== 10'h00a) begin n_fail++; $display("FAIL rstmid_first: got %h expected 00a", log_at(0)); end
      n_chk++; if (log_at(1) !== 10'h22f) begin n_fail++; $display("FAIL rstmid_second: got %h expected 22f", log_at(1)); end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_rdy    = 1'b1;
      en        = 4'hf;
      pend      = '0;
      cyc       = 0;
      dly       = 0;
      bcnt      = 0;
      stuck     = 1'b0;
      n_chk     = 0;
      n_fail    = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_packet_lock();
      test_timeout();
      test_valid_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
